d_flipflop: RTL and testbench
=============================

// Module: d_flipflop
// PURPOSE
//  Positive-edge D flip-flop with asynchronous active-low reset and complementary outputs.
//  Basic storage primitive used wherever a registered bit (or bit-vector) plus its
//  inverse is needed, e.g. pipeline staging or simple state holding.
//  Default configuration is a single bit.
// PARAMETERS
//  WIDTH    1  data width in bits of din, q and qb
//  RST_VAL  0  value q takes while reset is asserted (WIDTH bits; qb takes ~RST_VAL)
// PORTS
//  clk  input   1      clock; all state changes on rising edge, except reset
//  rst  input   1      reset, asynchronous, active-low (0 = reset asserted)
//  din  input   WIDTH  data input, sampled on rising clk edge
//  q    output  WIDTH  registered data
//  qb   output  WIDTH  bitwise complement of q
// BEHAVIOUR
//  - Instance port order: din, clk, rst, q, qb (positional instantiation relies on it).
//  - Reset:
//    - rst falling to 0 forces q=RST_VAL and qb=~RST_VAL immediately, with no clk edge needed.
//    - Outputs hold those values while rst=0, whatever clk and din do.
//  - Reset release:
//    - rst rising to 1 does not change q.
//    - The first capture happens on the first rising clk edge with rst=1.
//  - Normal operation (rst=1):
//    - On each rising clk edge, q <= din.
//    - q holds between edges; latency is exactly one rising edge from din to q.
//  - qb is always exactly ~q. Both come from the same state element, so they never
//    disagree, including during reset and at power-up after the first reset.
//  - Simultaneous events:
//    - A rising clk edge while rst=0 is ignored, because reset dominates.
//    - rst deasserting in the same timestep as a rising clk edge: the edge is ignored
//      and q stays RST_VAL.
//  - Reset mid-operation: an rst pulse of any length clears q at once, whatever was captured before.
//  - Before the first reset, q and qb are X. The bench must apply reset before
//    checking values.
//  - din changes between rising edges have no effect on q.
//  - No enable, no synchronous clear, no internal state other than the WIDTH-bit register.
// TESTING
//  (clk period 4 time units; stimulus driven on falling edge, checked after next rising edge)
//  1. Power-up: rst=0 for one cycle, then rst=1 -> q=0, qb=1 during reset and
//     until the first capture.
//  2. Capture sequence: din=1,0,1,0,1 on successive falling edges with rst=1
//     -> after each rising edge q=1,0,1,0,1 and qb=0,1,0,1,0.
//  3. Async reset mid-stream: with q=1, drive rst=0 midway between clock edges
//     -> q=0, qb=1 at once, before any clk edge.
//  4. Reset dominance: rst=0, din=1, apply 3 rising edges -> q stays 0 throughout.
//     Release rst -> q=1 after the next rising edge.
//  5. Hold: din toggles 0->1->0 between two rising edges -> q changes only to
//     the din value present at the edge.
//  6. WIDTH=8, RST_VAL=8'hA5: during reset q=8'hA5, qb=8'h5A.
//     After reset, din=8'h3C -> q=8'h3C, qb=8'hC3.

Source files
------------

// File: rtl/d_flipflop.sv
// Positive-edge D register with asynchronous active-low reset and a
// complementary output. qb is derived from the same register as q, so the
// two can never disagree, including while reset is held.
module d_flipflop #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic [WIDTH-1:0] din,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next state is simply the data input; no enable or synchronous clear.
    always_comb begin
        q_d = din;
    end

    // Storage element; reset forces RST_VAL immediately and dominates clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;

endmodule

// File: tb/tb_d_flipflop.sv
// Directed bench for d_flipflop: a default 1-bit instance and an 8-bit
// instance with a non-zero reset value.
`timescale 1ns/100ps
module tb_d_flipflop;

    logic       clk;
    logic       rst1;
    logic       din1;
    logic       q1;
    logic       qb1;
    logic       rst8;
    logic [7:0] din8;
    logic [7:0] q8;
    logic [7:0] qb8;

    int n_checks;
    int n_fail;

    d_flipflop u_dut1 (
        .din (din1),
        .clk (clk),
        .rst (rst1),
        .q   (q1),
        .qb  (qb1)
    );

    d_flipflop #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) u_dut8 (
        .din (din8),
        .clk (clk),
        .rst (rst8),
        .q   (q8),
        .qb  (qb8)
    );

    // 4 ns period: rising edges at 2, 6, 10, ...; falling edges at 4, 8, ...
    initial clk = 1'b0;
    always #2 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, got still running, want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        din1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
        #0.5;
        n_checks++;
        if (q1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_q: got %b want 0", q1);
        end
        n_checks++;
        if (qb1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_qb: got %b want 1", qb1);
        end
        // Edge during reset with din=1 must be ignored.
        din1 = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (q1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_q: got %b want 0", q1);
        end
        @(negedge clk);
        din1 = 1'b0;
        rst1 = 1'b1;
        #1;
        n_checks++;
        if (q1 !== 1'b0 || qb1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got q=%b qb=%b want q=0 qb=1", q1, qb1);
        end
    endtask

    task automatic test_capture();
        logic [4:0] pattern;
        pattern = 5'b10101;
        for (int i = 4; i >= 0; i--) begin
            @(negedge clk);
            din1 = pattern[i];
            @(posedge clk);
            #1;
            n_checks++;
            if (q1 !== pattern[i] || qb1 !== ~pattern[i]) begin
                n_fail++;
                $display("FAIL capture_%0d: got q=%b qb=%b want q=%b qb=%b",
                         4 - i, q1, qb1, pattern[i], ~pattern[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        // q is 1 after the capture sequence.
        @(negedge clk);
        #1;
        n_checks++;
        if (q1 !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre: got q=%b want 1", q1);
        end
        rst1 = 1'b0;
        #0.2;
        n_checks++;
        if (q1 !== 1'b0 || qb1 !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got q=%b qb=%b want q=0 qb=1", q1, qb1);
        end
    endtask

    task automatic test_reset_dominance();
        din1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (q1 !== 1'b0) begin
                n_fail++;
                $display("FAIL dominance_edge%0d: got q=%b want 0", i, q1);
            end
        end
        @(negedge clk);
        rst1 = 1'b1;
        #1;
        n_checks++;
        if (q1 !== 1'b0) begin
            n_fail++;
            $display("FAIL dominance_release: got q=%b want 0", q1);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (q1 !== 1'b1 || qb1 !== 1'b0) begin
            n_fail++;
            $display("FAIL dominance_capture: got q=%b qb=%b want q=1 qb=0", q1, qb1);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        din1 = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (q1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_setup: got q=%b want 0", q1);
        end
        // Toggle 0->1->0 between edges; value at the edge is 0.
        @(negedge clk);
        din1 = 1'b1;
        #0.5;
        n_checks++;
        if (q1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_between: got q=%b want 0", q1);
        end
        din1 = 1'b0;
        #0.5;
        din1 = 1'b1;
        #0.5;
        din1 = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (q1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_edge0: got q=%b want 0", q1);
        end
        // Toggle ending at 1 before the edge.
        @(negedge clk);
        din1 = 1'b0;
        #0.5;
        din1 = 1'b1;
        #0.5;
        din1 = 1'b0;
        #0.5;
        din1 = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (q1 !== 1'b1 || qb1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_edge1: got q=%b qb=%b want q=1 qb=0", q1, qb1);
        end
    endtask

    task automatic test_wide();
        @(negedge clk);
        din8 = 8'hFF;
        rst8 = 1'b0;
        #0.5;
        n_checks++;
        if (q8 !== 8'hA5 || qb8 !== 8'h5A) begin
            n_fail++;
            $display("FAIL wide_reset: got q=%h qb=%h want q=a5 qb=5a", q8, qb8);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (q8 !== 8'hA5) begin
            n_fail++;
            $display("FAIL wide_reset_hold: got q=%h want a5", q8);
        end
        @(negedge clk);
        rst8 = 1'b1;
        din8 = 8'h3C;
        #1;
        n_checks++;
        if (q8 !== 8'hA5) begin
            n_fail++;
            $display("FAIL wide_release: got q=%h want a5", q8);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (q8 !== 8'h3C || qb8 !== 8'hC3) begin
            n_fail++;
            $display("FAIL wide_capture: got q=%h qb=%h want q=3c qb=c3", q8, qb8);
        end
        @(negedge clk);
        din8 = 8'h81;
        @(posedge clk);
        #1;
        n_checks++;
        if (q8 !== 8'h81 || qb8 !== 8'h7E) begin
            n_fail++;
            $display("FAIL wide_capture2: got q=%h qb=%h want q=81 qb=7e", q8, qb8);
        end
        @(negedge clk);
        #1;
        rst8 = 1'b0;
        #0.2;
        n_checks++;
        if (q8 !== 8'hA5 || qb8 !== 8'h5A) begin
            n_fail++;
            $display("FAIL wide_async: got q=%h qb=%h want q=a5 qb=5a", q8, qb8);
        end
        @(negedge clk);
        rst8 = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst1     = 1'b1;
        rst8     = 1'b1;
        din1     = 1'b0;
        din8     = 8'h00;
        test_reset();
        test_capture();
        test_async_reset();
        test_reset_dominance();
        test_hold();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
